optical_tx_sequencer: RTL and testbench
=======================================

# optical_tx_sequencer

Sequences the 40 MHz transmit frame stream for the dual-GTP optical link: idle frames until both GTP channels report reset done, then a train of channel-bonding frames, then a start marker, then PRBS payload. A periodic restart re-sends the marker and restarts the PRBS, so a late-connecting receiver can lock. It sits between the PRBS generator and the 40→80 MHz clock-domain FIFOs that feed the GTP wrapper.

## Interface

- BOND_GAP, 32: cycles per bonding slot; one bonding frame is sent in the last cycle of each slot; must be ≥2
- BOND_COUNT, 255: number of bonding frames sent before the marker; must be ≥1
- RESTART_PERIOD, 32'h2638E98: restart timer terminal count (~1 s at 40 MHz)
- clock  in  1  40 MHz logic clock
- reset  in  1  synchronous, active-high
- gtp_reset_done  in  2  per-channel GTP reset done
- enable  in  1  payload enable; low = idle frames in payload phase
- prbs_data  in  48  PRBS generator output
- prbs_start  in  1  PRBS generator first-pattern strobe
- prbs_rst  out  1  PRBS generator reset
- tx_data  out  64  frame to the CDC FIFO
- tx_iskchar  out  8  K-char mask; bit i covers tx_data[8i+7:8i]
- state  out  2  0 WAIT_GTP, 1 BOND, 2 MARKER, 3 PAYLOAD
- bonding_done  out  1  high once BOND_COUNT bonding frames have been sent
- restart_pulse  out  1  one-cycle restart strobe
- inj_err_req  in  1  error-injection request pulse
- inj_err_cnt  out  16  number of injected errors, saturating

## Operation

- Frames:
  - IDLE: {4{16'h50BC}}, mask 8'b01010101
  - BOND: 64'h1CFEFBDC_00000000, mask 8'b11110000
  - MARKER: 64'hFCFCFCFCFCFCFCFC, mask 8'hFF
  - PAYLOAD: {prbs_data, 16'h50BC}, mask 8'b00000001
- WAIT_GTP: IDLE frames, prbs_rst=1. Go to BOND when gtp_reset_done==2'b11.
- BOND:
  - Slot counter runs 0..BOND_GAP-1 and wraps. BOND frame when counter==BOND_GAP-1, IDLE otherwise.
  - Each BOND frame increments the bond counter. After the BOND_COUNT-th frame, bonding_done=1 and the state goes to MARKER on the next cycle.
- MARKER: prbs_rst=1 for the first cycle in the state, then 0. IDLE frames until prbs_start=1; in that cycle the frame is MARKER and the state goes to PAYLOAD.
- PAYLOAD:
  - PAYLOAD frames while enable=1.
  - While enable=0: IDLE frames and prbs_rst=1.
  - When enable rises: go to MARKER.
- Restart timer:
  - Counts from reset; it does not clear on gtp_reset_done loss.
  - At RESTART_PERIOD it wraps to 0 and restart_pulse=1 for one cycle.
  - A pulse in PAYLOAD forces MARKER. A pulse in any other state is ignored.
- Loss of either gtp_reset_done bit in any state:
  - Next state is WAIT_GTP.
  - Slot and bond counters clear; bonding_done clears.
- Simultaneous events: gtp loss beats restart; restart beats enable rise; in MARKER, prbs_start is ignored during its prbs_rst cycle.

## Timing

- tx_data, tx_iskchar, prbs_rst, restart_pulse and state are all registered. A frame reflects the state and inputs of the previous cycle (1-cycle latency).
- Reset values:
  - tx_data = IDLE, tx_iskchar = 8'b01010101
  - state = 0, prbs_rst = 1
  - bonding_done = 0, restart_pulse = 0, inj_err_cnt = 0
  - all counters = 0
- Reset mid-operation returns to WAIT_GTP on the next edge and restarts bonding from slot 0.
- First BOND frame: BOND_GAP cycles after entry to BOND.

## Configuration

- OPT_TX_ERRINJ_EN defined:
  - inj_err_req sets a pending flag.
  - The next PAYLOAD frame with enable=1 has tx_data[16] inverted; the flag clears and inj_err_cnt increments, saturating at 16'hFFFF.
  - A request while the flag is already pending is merged into it.
  - The pending flag clears on reset and on gtp_reset_done loss.
- Undefined: inj_err_req is ignored and inj_err_cnt is tied to 0.

## Test plan

All scenarios use BOND_GAP=4, BOND_COUNT=3, RESTART_PERIOD=200.

- Both gtp_reset_done high at cycle 10 → BOND frames in cycles 15, 19, 23; bonding_done=1 after cycle 23; state=2 at cycle 24.
- In MARKER, prbs_start high 5 cycles after the prbs_rst cycle → one FC frame with mask FF, then payload {prbs_data,16'h50BC} with mask 01.
- restart_pulse fires while in PAYLOAD → prbs_rst pulse, one marker frame, payload resumes; no restart from BOND.
- gtp_reset_done=2'b10 mid-PAYLOAD → IDLE frames; bonding restarts with all 3 frames once it returns to 2'b11.
- enable low for 10 cycles in PAYLOAD → 10 IDLE frames, then MARKER, then PAYLOAD.
- With OPT_TX_ERRINJ_EN: two requests in MARKER → exactly one frame with bit 16 flipped, inj_err_cnt=1; without the macro, inj_err_cnt stays 0.

Source files
------------

// File: rtl/optical_tx_sequencer.sv
// optical_tx_sequencer
// Builds the 40 MHz transmit frame stream for the dual-GTP optical link.
// The stream goes through four phases: idle frames while the GTPs come out of
// reset, a train of channel-bonding frames, a start marker, and PRBS payload.
// A free-running restart timer sends the marker again and restarts the PRBS
// so that a receiver which connects late can still lock.
// Optional feature macro: OPT_TX_ERRINJ_EN enables single-bit error injection
// on payload frames. When it is undefined, inj_err_req is ignored and
// inj_err_cnt stays 0.
module optical_tx_sequencer #(
  parameter int unsigned BOND_GAP       = 32,
  parameter int unsigned BOND_COUNT     = 255,
  parameter logic [31:0] RESTART_PERIOD = 32'h2638E98
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  gtp_reset_done,
  input  logic        enable,
  input  logic [47:0] prbs_data,
  input  logic        prbs_start,
  output logic        prbs_rst,
  output logic [63:0] tx_data,
  output logic [7:0]  tx_iskchar,
  output logic [1:0]  state,
  output logic        bonding_done,
  output logic        restart_pulse,
  input  logic        inj_err_req,
  output logic [15:0] inj_err_cnt
);

  localparam logic [63:0] FRAME_IDLE   = {4{16'h50BC}};
  localparam logic [63:0] FRAME_BOND   = 64'h1CFEFBDC_00000000;
  localparam logic [63:0] FRAME_MARKER = 64'hFCFCFCFCFCFCFCFC;
  localparam logic [7:0]  MASK_IDLE    = 8'b01010101;
  localparam logic [7:0]  MASK_BOND    = 8'b11110000;
  localparam logic [7:0]  MASK_MARKER  = 8'hFF;
  localparam logic [7:0]  MASK_PAYLOAD = 8'b00000001;

  localparam int SLOT_W = (BOND_GAP > 2) ? $clog2(BOND_GAP) : 1;
  localparam int BOND_W = $clog2(BOND_COUNT + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BOND_GAP - 1);
  localparam logic [BOND_W-1:0] BOND_LAST = BOND_W'(BOND_COUNT - 1);

  typedef enum logic [1:0] {
    ST_WAIT_GTP = 2'd0,
    ST_BOND     = 2'd1,
    ST_MARKER   = 2'd2,
    ST_PAYLOAD  = 2'd3
  } state_t;

  state_t            cur_state;
  logic [SLOT_W-1:0] slot_cnt;
  logic [BOND_W-1:0] bond_cnt;
  logic [31:0]       restart_timer;
  logic              enable_q;

  logic gtp_ok;
  logic enable_rise;
  logic payload_fire;
  logic inj_flip;
  logic [63:0] err_flip;

  assign gtp_ok      = &gtp_reset_done;
  assign enable_rise = enable & ~enable_q;
  // A payload frame goes out only when nothing with higher priority
  // (link loss, restart, enable rise) pulls the state back to MARKER.
  assign payload_fire = gtp_ok && (cur_state == ST_PAYLOAD) && !restart_pulse
                        && !enable_rise && enable;
  assign err_flip = {47'd0, inj_flip, 16'd0};
  assign state    = cur_state;

  // Free-running restart timer; only a full reset clears it, a link drop does not.
  always_ff @(posedge clock) begin
    // NOTE: sequential state always uses non-blocking assignments, so every
    // register sees the values from before the edge regardless of block order.
    if (reset) begin
      restart_timer <= 32'd0;
      restart_pulse <= 1'b0;
    end else if (restart_timer == RESTART_PERIOD) begin
      restart_timer <= 32'd0;
      restart_pulse <= 1'b1;
    end else begin
      restart_timer <= restart_timer + 32'd1;
      restart_pulse <= 1'b0;
    end
  end

  // Sequencer FSM with registered frame, mask and PRBS reset outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state    <= ST_WAIT_GTP;
      slot_cnt     <= '0;
      bond_cnt     <= '0;
      bonding_done <= 1'b0;
      prbs_rst     <= 1'b1;
      enable_q     <= 1'b0;
      tx_data      <= FRAME_IDLE;
      tx_iskchar   <= MASK_IDLE;
    end else begin
      enable_q   <= enable;
      tx_data    <= FRAME_IDLE;
      tx_iskchar <= MASK_IDLE;
      if (!gtp_ok) begin
        // Losing either channel restarts the whole bring-up sequence.
        cur_state    <= ST_WAIT_GTP;
        slot_cnt     <= '0;
        bond_cnt     <= '0;
        bonding_done <= 1'b0;
        prbs_rst     <= 1'b1;
      end else begin
        unique case (cur_state)
          ST_WAIT_GTP: begin
            prbs_rst  <= 1'b1;
            slot_cnt  <= '0;
            bond_cnt  <= '0;
            cur_state <= ST_BOND;
          end
          ST_BOND: begin
            prbs_rst <= 1'b1;
            if (bonding_done) begin
              cur_state <= ST_MARKER;
            end else if (slot_cnt == SLOT_LAST) begin
              slot_cnt   <= '0;
              bond_cnt   <= bond_cnt + BOND_W'(1);
              tx_data    <= FRAME_BOND;
              tx_iskchar <= MASK_BOND;
              if (bond_cnt == BOND_LAST) bonding_done <= 1'b1;
            end else begin
              slot_cnt <= slot_cnt + SLOT_W'(1);
            end
          end
          ST_MARKER: begin
            // prbs_rst is high exactly in the first MARKER cycle, so it
            // doubles as the "ignore prbs_start" qualifier.
            prbs_rst <= 1'b0;
            if (!prbs_rst && prbs_start) begin
              tx_data    <= FRAME_MARKER;
              tx_iskchar <= MASK_MARKER;
              cur_state  <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            if (restart_pulse || enable_rise) begin
              prbs_rst  <= 1'b1;
              cur_state <= ST_MARKER;
            end else if (enable) begin
              prbs_rst   <= 1'b0;
              tx_data    <= {prbs_data, 16'h50BC} ^ err_flip;
              tx_iskchar <= MASK_PAYLOAD;
            end else begin
              prbs_rst <= 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef OPT_TX_ERRINJ_EN
  logic err_pending;

  assign inj_flip = err_pending;

  // Pending error request and saturating count of injected errors.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_pending <= 1'b0;
      inj_err_cnt <= 16'd0;
    end else if (!gtp_ok) begin
      err_pending <= 1'b0;
    end else begin
      if (payload_fire && err_pending && (inj_err_cnt != 16'hFFFF))
        inj_err_cnt <= inj_err_cnt + 16'd1;
      err_pending <= inj_err_req | (err_pending & ~payload_fire);
    end
  end
`else
  logic unused_inj_req;

  assign unused_inj_req = inj_err_req;
  assign inj_flip       = 1'b0;
  assign inj_err_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_optical_tx_sequencer.sv
// Directed testbench for optical_tx_sequencer with BOND_GAP=4, BOND_COUNT=3
// and RESTART_PERIOD=200. n counts the clock edges since reset was released.
// After edge n the restart timer holds n mod 201, so the first restart pulse
// is visible after edge 201 and the second after edge 402.
module tb_optical_tx_sequencer;

  localparam logic [63:0] IDLE_F = 64'h50BC50BC50BC50BC;
  localparam logic [63:0] BOND_F = 64'h1CFEFBDC00000000;
  localparam logic [63:0] MARK_F = 64'hFCFCFCFCFCFCFCFC;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  gtp_reset_done;
  logic        enable;
  logic [47:0] prbs_data;
  logic        prbs_start;
  logic        prbs_rst;
  logic [63:0] tx_data;
  logic [7:0]  tx_iskchar;
  logic [1:0]  state;
  logic        bonding_done;
  logic        restart_pulse;
  logic        inj_err_req;
  logic [15:0] inj_err_cnt;

  int errors = 0;
  int checks = 0;
  int n = 0;
  int idle_cnt;
  logic [63:0] exp_err_frame;
  logic [15:0] exp_cnt;

  optical_tx_sequencer #(
    .BOND_GAP(4),
    .BOND_COUNT(3),
    .RESTART_PERIOD(32'd200)
  ) dut (
    .clock(clock),
    .reset(reset),
    .gtp_reset_done(gtp_reset_done),
    .enable(enable),
    .prbs_data(prbs_data),
    .prbs_start(prbs_start),
    .prbs_rst(prbs_rst),
    .tx_data(tx_data),
    .tx_iskchar(tx_iskchar),
    .state(state),
    .bonding_done(bonding_done),
    .restart_pulse(restart_pulse),
    .inj_err_req(inj_err_req),
    .inj_err_cnt(inj_err_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) n <= 0;
    else n <= n + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_to(input int target);
    while (n < target) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, n, observed, expected);
    end
  endtask

  initial begin
`ifdef OPT_TX_ERRINJ_EN
    exp_err_frame = 64'h123456789ABC_50BC;
    exp_cnt       = 16'd1;
`else
    exp_err_frame = 64'h123456789ABD_50BC;
    exp_cnt       = 16'd0;
`endif
    reset = 1'b1; gtp_reset_done = 2'b00; enable = 1'b1;
    prbs_data = 48'd0; prbs_start = 1'b0; inj_err_req = 1'b0;
    repeat (2) tick();

    // Reset values
    check("rst_tx_data", tx_data, IDLE_F);
    check("rst_mask", 64'(tx_iskchar), 64'h55);
    check("rst_state", 64'(state), 64'd0);
    check("rst_prbs_rst", 64'(prbs_rst), 64'd1);
    check("rst_bonding_done", 64'(bonding_done), 64'd0);
    check("rst_restart_pulse", 64'(restart_pulse), 64'd0);
    check("rst_inj_cnt", 64'(inj_err_cnt), 64'd0);
    reset = 1'b0;

    // WAIT_GTP until both channels report reset done
    tick_to(10);
    check("wait_state", 64'(state), 64'd0);
    check("wait_prbs_rst", 64'(prbs_rst), 64'd1);
    gtp_reset_done = 2'b11;
    tick_to(11);
    check("bond_entry_state", 64'(state), 64'd1);
    check("bond_entry_idle", tx_data, IDLE_F);
    tick_to(14);
    check("bond_slot3_idle", tx_data, IDLE_F);
    tick_to(15);
    check("bond1_frame", tx_data, BOND_F);
    check("bond1_mask", 64'(tx_iskchar), 64'hF0);
    check("bond1_not_done", 64'(bonding_done), 64'd0);
    tick_to(16);
    check("bond_gap_idle", tx_data, IDLE_F);
    tick_to(19);
    check("bond2_frame", tx_data, BOND_F);
    tick_to(23);
    check("bond3_frame", tx_data, BOND_F);
    check("bond3_done", 64'(bonding_done), 64'd1);
    check("bond3_state", 64'(state), 64'd1);
    tick_to(24);
    check("marker_state", 64'(state), 64'd2);
    check("marker_prbs_rst", 64'(prbs_rst), 64'd1);

    // prbs_start during the prbs_rst cycle must be ignored
    prbs_start = 1'b1;
    tick_to(25);
    check("marker_ignore_start", 64'(state), 64'd2);
    check("marker_prbs_rst_low", 64'(prbs_rst), 64'd0);
    prbs_start = 1'b0;

    // Two error-injection requests while in MARKER
    tick_to(26); inj_err_req = 1'b1;
    tick_to(27); inj_err_req = 1'b0;
    tick_to(28); inj_err_req = 1'b1;
    tick_to(29); inj_err_req = 1'b0;
    check("marker_wait_idle", tx_data, IDLE_F);
    prbs_start = 1'b1;
    tick_to(30);
    check("marker_frame", tx_data, MARK_F);
    check("marker_mask", 64'(tx_iskchar), 64'hFF);
    check("payload_state", 64'(state), 64'd3);
    prbs_start = 1'b0;
    prbs_data  = 48'h123456789ABD;
    tick_to(31);
    check("payload1_frame", tx_data, exp_err_frame);
    check("payload1_mask", 64'(tx_iskchar), 64'h01);
    check("inj_cnt_after1", 64'(inj_err_cnt), 64'(exp_cnt));
    prbs_data = 48'hA5A55A5A0F0F;
    tick_to(32);
    check("payload2_frame", tx_data, 64'hA5A55A5A0F0F_50BC);
    check("inj_cnt_after2", 64'(inj_err_cnt), 64'(exp_cnt));

    // Enable low for 10 cycles
    enable = 1'b0;
    idle_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (tx_data === IDLE_F && prbs_rst === 1'b1 && state === 2'd3) idle_cnt++;
    end
    check("enable_low_idles", 64'(idle_cnt), 64'd10);
    enable = 1'b1;
    tick_to(43);
    check("enable_rise_state", 64'(state), 64'd2);
    check("enable_rise_prbs_rst", 64'(prbs_rst), 64'd1);
    tick_to(45);
    prbs_start = 1'b1;
    tick_to(46);
    check("remarker_frame", tx_data, MARK_F);
    prbs_start = 1'b0;
    prbs_data  = 48'h00FF00FF00FE;
    tick_to(47);
    check("repayload_frame", tx_data, 64'h00FF00FF00FE_50BC);
    check("repayload_state", 64'(state), 64'd3);

    // Restart timer fires while in PAYLOAD
    tick_to(200);
    check("pre_restart_pulse", 64'(restart_pulse), 64'd0);
    tick_to(201);
    check("restart_pulse", 64'(restart_pulse), 64'd1);
    tick_to(202);
    check("restart_state", 64'(state), 64'd2);
    check("restart_prbs_rst", 64'(prbs_rst), 64'd1);
    check("restart_one_cycle", 64'(restart_pulse), 64'd0);
    tick_to(203);
    prbs_start = 1'b1;
    tick_to(204);
    check("restart_marker", tx_data, MARK_F);
    prbs_start = 1'b0;
    prbs_data  = 48'hCAFEF00DBEEE;
    tick_to(205);
    check("restart_payload", tx_data, 64'hCAFEF00DBEEE_50BC);

    // Loss of one GTP channel mid-PAYLOAD
    tick_to(210);
    gtp_reset_done = 2'b10;
    tick_to(211);
    check("loss_state", 64'(state), 64'd0);
    check("loss_idle", tx_data, IDLE_F);
    check("loss_prbs_rst", 64'(prbs_rst), 64'd1);
    check("loss_bonding_done", 64'(bonding_done), 64'd0);
    tick_to(390);
    gtp_reset_done = 2'b11;
    tick_to(391);
    check("rebond_state", 64'(state), 64'd1);
    tick_to(395);
    check("rebond1_frame", tx_data, BOND_F);
    tick_to(399);
    check("rebond2_frame", tx_data, BOND_F);
    tick_to(402);
    check("bond_restart_pulse", 64'(restart_pulse), 64'd1);
    check("bond_restart_ignored", 64'(state), 64'd1);
    tick_to(403);
    check("rebond3_frame", tx_data, BOND_F);
    check("rebond3_done", 64'(bonding_done), 64'd1);
    tick_to(404);
    check("rebond_marker_state", 64'(state), 64'd2);

    // Reset mid-operation
    reset = 1'b1;
    tick();
    check("midrst_state", 64'(state), 64'd0);
    check("midrst_tx", tx_data, IDLE_F);
    check("midrst_prbs_rst", 64'(prbs_rst), 64'd1);
    check("midrst_bonding_done", 64'(bonding_done), 64'd0);
    check("midrst_inj_cnt", 64'(inj_err_cnt), 64'd0);
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
